// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: FSM state encoding,
// frame geometry and the parity helper.
package uart_pkg;

   localparam int DATA_BITS                 = 8;
   localparam int CLOCK_SCALE_WIDTH_DEFAULT = 16;
   localparam int BIT_CNT_W                 = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_e;

   // Even parity is the XOR of the data bits; odd parity inverts it.
   function automatic logic parity_bit(input logic [DATA_BITS-1:0] data, input logic odd);
      return (^data) ^ odd;
   endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: loaded with the period N, counts N-1 down to 0 and
// flags the final cycle of each bit, reloading itself while running.
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLOCK_SCALE_WIDTH = CLOCK_SCALE_WIDTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic                         run,
   input  logic [CLOCK_SCALE_WIDTH-1:0] period,
   output logic                         bitDone
);

   localparam logic [CLOCK_SCALE_WIDTH-1:0] ONE  = {{(CLOCK_SCALE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CLOCK_SCALE_WIDTH-1:0] ZERO = {CLOCK_SCALE_WIDTH{1'b0}};

   logic [CLOCK_SCALE_WIDTH-1:0] count_q;
   logic [CLOCK_SCALE_WIDTH-1:0] count_d;
   logic [CLOCK_SCALE_WIDTH-1:0] reload_s;

   // Next count: period is always >= 1 here, so period-1 never wraps.
   always_comb begin
      reload_s = period - ONE;
      count_d  = count_q;
      if (load) begin
         count_d = reload_s;
      end else if (!run) begin
         count_d = ZERO;
      end else if (count_q == ZERO) begin
         count_d = reload_s;
      end else begin
         count_d = count_q - ONE;
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= ZERO;
      end else begin
         count_q <= count_d;
      end
   end

   assign bitDone = run && (count_q == ZERO);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from an upstream buffer and serialises them as
// start / 8 data (LSB first) / optional parity / one or two stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLOCK_SCALE_WIDTH = CLOCK_SCALE_WIDTH_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic [CLOCK_SCALE_WIDTH-1:0] cyclesPerBit,
   input  logic                         parityEnable,
   input  logic                         parityOdd,
   input  logic                         twoStopBits,
   input  logic [DATA_BITS-1:0]         fifoData,
   input  logic                         fifoIsData,
   output logic                         fifoOe,
   output logic                         tx,
   output logic                         busy,
   output logic                         frameDone
);

   localparam logic [CLOCK_SCALE_WIDTH-1:0] ONE      = {{(CLOCK_SCALE_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CLOCK_SCALE_WIDTH-1:0] ZERO     = {CLOCK_SCALE_WIDTH{1'b0}};
   localparam logic [BIT_CNT_W-1:0]         LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);
   localparam logic [BIT_CNT_W-1:0]         CNT_ONE  = {{(BIT_CNT_W-1){1'b0}}, 1'b1};

   uart_state_e                  state_q,       state_d;
   logic [DATA_BITS-1:0]         shift_q,       shift_d;
   logic [BIT_CNT_W-1:0]         bit_cnt_q,     bit_cnt_d;
   logic [CLOCK_SCALE_WIDTH-1:0] period_q,      period_d;
   logic                         parity_en_q,   parity_en_d;
   logic                         parity_bit_q,  parity_bit_d;
   logic                         two_stop_q,    two_stop_d;
   logic                         stop_second_q, stop_second_d;
   logic                         tx_q,          tx_d;
   logic                         fifo_oe_q,     fifo_oe_d;
   logic                         busy_q,        busy_d;
   logic                         frame_done_q,  frame_done_d;

   logic                         start_s;
   logic                         bit_done_s;
   logic                         timer_run_s;
   logic [CLOCK_SCALE_WIDTH-1:0] cfg_period_s;
   logic [CLOCK_SCALE_WIDTH-1:0] timer_period_s;

   // A programmed period of zero behaves as one cycle per bit.
   always_comb begin
      if (cyclesPerBit == ZERO) begin
         cfg_period_s = ONE;
      end else begin
         cfg_period_s = cyclesPerBit;
      end
      start_s     = (state_q == IDLE) && enable && fifoIsData;
      timer_run_s = (state_q != IDLE);
      if (state_q == IDLE) begin
         timer_period_s = cfg_period_s;
      end else begin
         timer_period_s = period_q;
      end
   end

   uart_bit_timer #(
      .CLOCK_SCALE_WIDTH (CLOCK_SCALE_WIDTH)
   ) u_bit_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (start_s),
      .run     (timer_run_s),
      .period  (timer_period_s),
      .bitDone (bit_done_s)
   );

   // Frame sequencer: next state and next registered outputs.
   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      period_d      = period_q;
      parity_en_d   = parity_en_q;
      parity_bit_d  = parity_bit_q;
      two_stop_d    = two_stop_q;
      stop_second_d = stop_second_q;
      tx_d          = tx_q;
      fifo_oe_d     = 1'b0;
      frame_done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (start_s) begin
               state_d       = START;
               shift_d       = fifoData;
               bit_cnt_d     = {BIT_CNT_W{1'b0}};
               period_d      = cfg_period_s;
               parity_en_d   = parityEnable;
               parity_bit_d  = parity_bit(fifoData, parityOdd);
               two_stop_d    = twoStopBits;
               stop_second_d = 1'b0;
               tx_d          = 1'b0;
               fifo_oe_d     = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (bit_done_s) begin
               state_d = DATA;
               tx_d    = shift_q[0];
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (!bit_done_s) begin
               state_d = DATA;
            end else if (bit_cnt_q != LAST_BIT) begin
               bit_cnt_d = bit_cnt_q + CNT_ONE;
               shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
               tx_d      = shift_q[1];
            end else if (parity_en_q) begin
               state_d = PARITY;
               tx_d    = parity_bit_q;
            end else begin
               state_d       = STOP;
               stop_second_d = 1'b0;
               tx_d          = 1'b1;
            end
         end
         PARITY: begin
            if (bit_done_s) begin
               state_d       = STOP;
               stop_second_d = 1'b0;
               tx_d          = 1'b1;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            tx_d = 1'b1;
            if (!bit_done_s) begin
               state_d = STOP;
            end else if (two_stop_q && !stop_second_q) begin
               stop_second_d = 1'b1;
            end else begin
               state_d      = IDLE;
               frame_done_d = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // State and output registers; reset aborts any frame in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         shift_q       <= {DATA_BITS{1'b0}};
         bit_cnt_q     <= {BIT_CNT_W{1'b0}};
         period_q      <= ZERO;
         parity_en_q   <= 1'b0;
         parity_bit_q  <= 1'b0;
         two_stop_q    <= 1'b0;
         stop_second_q <= 1'b0;
         tx_q          <= 1'b1;
         fifo_oe_q     <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         period_q      <= period_d;
         parity_en_q   <= parity_en_d;
         parity_bit_q  <= parity_bit_d;
         two_stop_q    <= two_stop_d;
         stop_second_q <= stop_second_d;
         tx_q          <= tx_d;
         fifo_oe_q     <= fifo_oe_d;
         busy_q        <= busy_d;
         frame_done_q  <= frame_done_d;
      end
   end

   assign tx        = tx_q;
   assign fifoOe    = fifo_oe_q;
   assign busy      = busy_q;
   assign frameDone = frame_done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a negedge
// monitor rebuilds each frame's line waveform from the framing rules.
module tb_uart_tx;

   localparam int W      = 16;
   localparam int BUDGET = 3000;

   typedef struct {
      logic [7:0] d;
      int         n;
      bit         par;
      bit         odd;
      bit         two;
   } frame_t;

   logic         clk;
   logic         rst;
   logic         enable;
   logic [W-1:0] cyclesPerBit;
   logic         parityEnable;
   logic         parityOdd;
   logic         twoStopBits;
   logic [7:0]   fifoData;
   logic         fifoIsData;
   logic         fifoOe;
   logic         tx;
   logic         busy;
   logic         frameDone;

   int checks   = 0;
   int failures = 0;

   frame_t     sb_q[$];
   logic [7:0] push_q[$];
   logic [7:0] fq[$];

   bit     mon_in_frame = 1'b0;
   frame_t cur;
   int     cur_n    = 1;
   int     flen     = 0;
   int     cyc      = 0;
   int     wave_err = 0;
   int     oe_err   = 0;
   int     busy_err = 0;
   int     done_err = 0;

   uart_tx #(.CLOCK_SCALE_WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .cyclesPerBit (cyclesPerBit),
      .parityEnable (parityEnable),
      .parityOdd    (parityOdd),
      .twoStopBits  (twoStopBits),
      .fifoData     (fifoData),
      .fifoIsData   (fifoIsData),
      .fifoOe       (fifoOe),
      .tx           (tx),
      .busy         (busy),
      .frameDone    (frameDone)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   // Line level of bit slot idx: start, data LSB first, optional parity, stop ones.
   function automatic bit exp_level(input frame_t f, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return f.d[idx-1];
      if (idx == 9 && f.par) return (($countones(f.d) % 2) == 1) ^ f.odd;
      return 1'b1;
   endfunction

   task automatic frame_cycle();
      if (tx !== exp_level(cur, cyc / cur_n)) wave_err++;
      if (fifoOe !== ((cyc == 0) ? 1'b1 : 1'b0)) oe_err++;
      if (busy !== 1'b1) busy_err++;
      if (frameDone !== 1'b0) done_err++;
      cyc++;
   endtask

   // Monitor: owns the upstream buffer model and checks every cycle at negedge.
   initial begin : monitor
      bit exp_start = 1'b0;
      bit rst_prev  = 1'b1;
      fifoIsData = 1'b0;
      fifoData   = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_prev) begin
            check("reset_tx", 32'(tx), 32'd1);
            check("reset_busy", 32'(busy), 32'd0);
            check("reset_oe", 32'(fifoOe), 32'd0);
            check("reset_done", 32'(frameDone), 32'd0);
            mon_in_frame = 1'b0;
         end else if (mon_in_frame && cyc == flen) begin
            check("frame_wave", 32'(wave_err), 32'd0);
            check("frame_oe_single", 32'(oe_err), 32'd0);
            check("frame_busy", 32'(busy_err), 32'd0);
            check("frame_done_early", 32'(done_err), 32'd0);
            check("frame_done_pulse", 32'(frameDone), 32'd1);
            check("end_busy", 32'(busy), 32'd0);
            check("end_oe", 32'(fifoOe), 32'd0);
            check("end_tx", 32'(tx), 32'd1);
            mon_in_frame = 1'b0;
         end else if (mon_in_frame) begin
            frame_cycle();
         end else begin
            check("start_decision", 32'(fifoOe), 32'(exp_start));
            if (fifoOe) begin
               check("pop_expected", 32'(sb_q.size() != 0), 32'd1);
               if (fq.size() != 0) void'(fq.pop_front());
               if (sb_q.size() != 0) begin
                  cur      = sb_q.pop_front();
                  cur_n    = (cur.n == 0) ? 1 : cur.n;
                  flen     = cur_n * (10 + int'(cur.par) + int'(cur.two));
                  cyc      = 0;
                  wave_err = 0;
                  oe_err   = 0;
                  busy_err = 0;
                  done_err = 0;
                  mon_in_frame = 1'b1;
                  frame_cycle();
               end
            end else begin
               check("idle_tx", 32'(tx), 32'd1);
               check("idle_busy", 32'(busy), 32'd0);
               check("idle_done", 32'(frameDone), 32'd0);
            end
         end
         while (push_q.size() != 0) fq.push_back(push_q.pop_front());
         fifoIsData = (fq.size() != 0);
         fifoData   = (fq.size() != 0) ? fq[0] : 8'h00;
         exp_start  = !mon_in_frame && enable && fifoIsData && !rst;
         rst_prev   = rst;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic cfg(input int n, input bit p, input bit o, input bit t);
      cyclesPerBit = W'(n);
      parityEnable = p;
      parityOdd    = o;
      twoStopBits  = t;
   endtask

   task automatic expect_frame(input logic [7:0] d);
      frame_t f;
      f.d   = d;
      f.n   = int'(cyclesPerBit);
      f.par = parityEnable;
      f.odd = parityOdd;
      f.two = twoStopBits;
      sb_q.push_back(f);
   endtask

   task automatic push(input logic [7:0] d, input bit expect_it);
      push_q.push_back(d);
      if (expect_it) expect_frame(d);
   endtask

   task automatic drain();
      int k = 0;
      while ((sb_q.size() != 0 || mon_in_frame) && k < BUDGET) begin
         tick(1);
         k++;
      end
      check("drain_in_time", 32'(k < BUDGET), 32'd1);
      if (k >= BUDGET) sb_q.delete();
      tick(2);
   endtask

   task automatic wait_start();
      int k = 0;
      while (!mon_in_frame && k < BUDGET) begin
         tick(1);
         k++;
      end
      check("start_in_time", 32'(k < BUDGET), 32'd1);
   endtask

   initial begin : stimulus
      rst    = 1'b1;
      enable = 1'b0;
      cfg(4, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #2;
      rst    = 1'b0;
      enable = 1'b1;
      tick(3);

      cfg(4, 1'b0, 1'b0, 1'b0); push(8'h55, 1'b1); drain();
      cfg(4, 1'b1, 1'b0, 1'b0); push(8'h07, 1'b1); drain();
      cfg(4, 1'b1, 1'b1, 1'b0); push(8'h07, 1'b1); drain();
      cfg(0, 1'b0, 1'b0, 1'b0); push(8'hA3, 1'b1); drain();
      cfg(2, 1'b0, 1'b0, 1'b1); push(8'h01, 1'b1); push(8'h80, 1'b1); drain();

      // Configuration churn while a frame is on the line.
      cfg(3, 1'b1, 1'b1, 1'b0); push(8'hC6, 1'b1); wait_start();
      cfg(int'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b1);
      tick(5);
      cfg(int'($urandom_range(5, 9)), 1'b1, 1'b0, 1'b0);
      drain();

      // Reset during data bit 3 with another byte waiting.
      cfg(4, 1'b0, 1'b0, 1'b0); push(8'h96, 1'b1); push(8'h3C, 1'b1); wait_start();
      tick(16);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      drain();

      // Disabled with data available, then re-enabled.
      enable = 1'b0;
      push(8'h5A, 1'b0);
      tick(100);
      enable = 1'b1;
      expect_frame(8'h5A);
      drain();

      // Enable dropped mid-frame: current frame completes, next byte waits.
      cfg(2, 1'b1, 1'b0, 1'b0); push(8'h11, 1'b1); push(8'h22, 1'b0); wait_start();
      enable = 1'b0;
      drain();
      tick(20);
      enable = 1'b1;
      expect_frame(8'h22);
      drain();

      for (int g = 0; g < 25; g++) begin
         int nb;
         cfg(int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         nb = int'($urandom_range(1, 3));
         for (int b = 0; b < nb; b++) push(8'($urandom), 1'b1);
         drain();
      end

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      check("buffer_empty", 32'(fq.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
